// File: rtl/serial_tx.sv
// Strobe-paced serial transmitter: start bit, LSB-first payload, optional parity, stop bit(s).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between payload and stop.
module serial_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 bit_strobe,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif
  localparam logic [2:0] ST_STOP   = 3'd5;

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shift;
  logic [CNT_W-1:0]     cnt;
`ifdef SERIAL_TX_PARITY_EN
  logic                 parity;
`endif

  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = (state != ST_IDLE);

  // cnt counts payload bits in DATA and elapsed stop periods in STOP
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      shift      <= '0;
      cnt        <= '0;
      serial_out <= 1'b1;
      tx_done    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tx_valid) begin
            shift <= tx_data;
`ifdef SERIAL_TX_PARITY_EN
            parity <= ^tx_data;
`endif
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (bit_strobe) begin
            serial_out <= 1'b0;
            state      <= ST_START;
          end
        end
        ST_START: begin
          if (bit_strobe) begin
            serial_out <= shift[0];
            shift      <= {1'b0, shift[DATA_BITS-1:1]};
            cnt        <= CNT_ONE;
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_strobe) begin
            if (cnt == DATA_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              serial_out <= parity;
              state      <= ST_PARITY;
`else
              serial_out <= 1'b1;
              cnt        <= CNT_ONE;
              state      <= ST_STOP;
`endif
            end else begin
              serial_out <= shift[0];
              shift      <= {1'b0, shift[DATA_BITS-1:1]};
              cnt        <= cnt + CNT_ONE;
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_strobe) begin
            serial_out <= 1'b1;
            cnt        <= CNT_ONE;
            state      <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (bit_strobe) begin
            if (cnt == STOP_LAST) begin
              cnt     <= '0;
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
